// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and op decode.
// PIPELINED_SHIFTER_ROTATE_EN enables rotate-right on op 11; otherwise op 11 behaves as SRL.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  function automatic op_e decode_op(input logic [1:0] raw);
    op_e op;
    case (raw)
      2'b00:   op = OP_SLL;
      2'b01:   op = OP_SRL;
      2'b10:   op = OP_SRA;
`ifdef PIPELINED_SHIFTER_ROTATE_EN
      2'b11:   op = OP_ROR;
`else
      2'b11:   op = OP_SRL;
`endif
      default: op = OP_SRL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One shift level of the barrel shifter: conditional right shift by DIST plus its pipeline register.
// Rotate fill is present only when PIPELINED_SHIFTER_ROTATE_EN is defined.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int DIST  = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     up_valid,
  input  op_e                      up_op,
  input  logic [$clog2(WIDTH)-1:0] up_shamt,
  input  logic                     up_fill,
  input  logic [WIDTH-1:0]         up_data,
  input  logic [TAG_W-1:0]         up_tag,
  output logic                     up_ready,
  input  logic                     down_ready,
  output logic                     down_valid,
  output op_e                      down_op,
  output logic [$clog2(WIDTH)-1:0] down_shamt,
  output logic                     down_fill,
  output logic [WIDTH-1:0]         down_data,
  output logic [TAG_W-1:0]         down_tag
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int BIT     = $clog2(DIST);

  typedef struct packed {
    logic               valid;
    op_e                op;
    logic [SHAMT_W-1:0] shamt;
    logic               fill;
    logic [WIDTH-1:0]   data;
    logic [TAG_W-1:0]   tag;
  } stage_t;

  stage_t           stage_r;
  logic [WIDTH-1:0] shifted;
  logic [DIST-1:0]  fill_bits;

  // Bits entering from the top: replicated fill, or the bits shifted out when rotating
  always_comb begin
    fill_bits = {DIST{up_fill}};
`ifdef PIPELINED_SHIFTER_ROTATE_EN
    if (up_op == OP_ROR) begin
      fill_bits = up_data[DIST-1:0];
    end else begin
      fill_bits = {DIST{up_fill}};
    end
`endif
    if (up_shamt[BIT]) begin
      shifted = {fill_bits, up_data[WIDTH-1:DIST]};
    end else begin
      shifted = up_data;
    end
  end

  // Capture when empty or when the current occupant moves on this cycle
  assign up_ready = !stage_r.valid || down_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stage_r <= '0;
    end else if (flush) begin
      stage_r.valid <= 1'b0;
    end else if (up_ready) begin
      stage_r.valid <= up_valid;
      if (up_valid) begin
        stage_r.op    <= up_op;
        stage_r.shamt <= up_shamt;
        stage_r.fill  <= up_fill;
        stage_r.data  <= shifted;
        stage_r.tag   <= up_tag;
      end
    end
  end

  assign down_valid = stage_r.valid;
  assign down_op    = stage_r.op;
  assign down_shamt = stage_r.shamt;
  assign down_fill  = stage_r.fill;
  assign down_data  = stage_r.data;
  assign down_tag   = stage_r.tag;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA, optional ROR) with valid/ready flow, tag and flush.
// Define PIPELINED_SHIFTER_ROTATE_EN to make op 11 rotate right instead of SRL.
module pipelined_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_zero
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int LEVELS  = SHAMT_W;

  // Index 0 is the entry point, index k+1 is the register of stage k
  logic [LEVELS:0]    v;
  logic [LEVELS:0]    fl;
  logic [LEVELS:0]    rdy;
  op_e                op_a [0:LEVELS];
  logic [SHAMT_W-1:0] sh   [0:LEVELS];
  logic [WIDTH-1:0]   d    [0:LEVELS];
  logic [TAG_W-1:0]   tg   [0:LEVELS];

  op_e              entry_op;
  logic [WIDTH-1:0] entry_data;
  logic [WIDTH-1:0] exit_data;

  // Left shifts ride the right-shift datapath on a bit-reversed operand
  always_comb begin
    entry_op   = decode_op(in_op);
    entry_data = in_data;
    if (entry_op == OP_SLL) begin
      for (int i = 0; i < WIDTH; i++) begin
        entry_data[i] = in_data[WIDTH-1-i];
      end
    end else begin
      entry_data = in_data;
    end
  end

  assign v[0]        = in_valid;
  assign op_a[0]     = entry_op;
  assign sh[0]       = in_shamt;
  assign fl[0]       = (entry_op == OP_SRA) && in_data[WIDTH-1];
  assign d[0]        = entry_data;
  assign tg[0]       = in_tag;
  assign rdy[LEVELS] = out_ready;
  assign in_ready    = rdy[0];

  for (genvar k = 0; k < LEVELS; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .DIST  (1 << (LEVELS - 1 - k))
    ) u_stage (
      .clock      (clock),
      .reset_n    (reset_n),
      .flush      (flush),
      .up_valid   (v[k]),
      .up_op      (op_a[k]),
      .up_shamt   (sh[k]),
      .up_fill    (fl[k]),
      .up_data    (d[k]),
      .up_tag     (tg[k]),
      .up_ready   (rdy[k]),
      .down_ready (rdy[k+1]),
      .down_valid (v[k+1]),
      .down_op    (op_a[k+1]),
      .down_shamt (sh[k+1]),
      .down_fill  (fl[k+1]),
      .down_data  (d[k+1]),
      .down_tag   (tg[k+1])
    );
  end

  // Undo the entry reversal for left shifts
  always_comb begin
    exit_data = d[LEVELS];
    if (op_a[LEVELS] == OP_SLL) begin
      for (int i = 0; i < WIDTH; i++) begin
        exit_data[i] = d[LEVELS][WIDTH-1-i];
      end
    end else begin
      exit_data = d[LEVELS];
    end
  end

  logic unused_tail;
  assign unused_tail = ^{sh[LEVELS], fl[LEVELS]};

  assign out_valid = v[LEVELS];
  assign out_data  = exit_data;
  assign out_tag   = tg[LEVELS];
  assign out_zero  = (d[LEVELS] == '0);

endmodule
